// File: rtl/ddram_pkg.sv
// Shared DDRAM burst-interface widths, responder state encoding and helpers.
package ddram_pkg;

    localparam int unsigned DDRAM_AW  = 29;
    localparam int unsigned DDRAM_DW  = 64;
    localparam int unsigned DDRAM_BEW = 8;
    localparam int unsigned BURST_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RBURST = 2'd2
    } state_t;

    // A burst count of zero is served as a single beat.
    function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] cnt);
        return (cnt == '0) ? BURST_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/ddram_bram.sv
// Single-port 2^AW x 64 block RAM with byte write enables and a registered read.
module ddram_bram
    import ddram_pkg::*;
#(
    parameter int unsigned AW        = 12,
    parameter string       INIT_FILE = ""
)
(
    input  logic                 clk,
    input  logic [AW-1:0]        addr,
    input  logic                 we,
    input  logic [DDRAM_BEW-1:0] be,
    input  logic [DDRAM_DW-1:0]  din,
    output logic [DDRAM_DW-1:0]  q
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DDRAM_DW-1:0] mem [DEPTH];

    // Power-up contents: all zero.
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[AW'(i)] = '0;
        end
    end

    // Byte-masked write and registered read on the shared port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(DDRAM_BEW); b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= din[b*8 +: 8];
                end
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/ddram_bram_responder.sv
// DDRAM burst responder backed by on-chip block RAM; stands in for DDR3.
module ddram_bram_responder
    import ddram_pkg::*;
#(
    parameter int unsigned AW        = 12,
    parameter string       INIT_FILE = ""
)
(
    input  logic                 DDRAM_CLK,
    input  logic                 reset,
    output logic                 DDRAM_BUSY,
    input  logic [BURST_W-1:0]   DDRAM_BURSTCNT,
    input  logic [DDRAM_AW-1:0]  DDRAM_ADDR,
    output logic [DDRAM_DW-1:0]  DDRAM_DOUT,
    output logic                 DDRAM_DOUT_READY,
    input  logic                 DDRAM_RD,
    input  logic [DDRAM_DW-1:0]  DDRAM_DIN,
    input  logic [DDRAM_BEW-1:0] DDRAM_BE,
    input  logic                 DDRAM_WE
);

    state_t              state;
    logic [AW-1:0]       ptr;
    logic [BURST_W-1:0]  cnt;
    logic                rd_pend;
    logic [DDRAM_DW-1:0] ram_q;

    logic [BURST_W-1:0]  burst_n_c;
    logic [AW-1:0]       ram_addr_c;
    logic                ram_we_c;
    logic                rd_issue_c;

    // Address bits above the RAM size are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^DDRAM_ADDR[DDRAM_AW-1:AW];

    // RAM port steering: IDLE takes the command address, bursts use the running pointer.
    always_comb begin
        burst_n_c  = burst_len(DDRAM_BURSTCNT);
        ram_addr_c = (state == IDLE) ? DDRAM_ADDR[AW-1:0] : ptr;
        ram_we_c   = 1'b0;
        rd_issue_c = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    rd_issue_c = DDRAM_RD;
                    ram_we_c   = DDRAM_WE && !DDRAM_RD;
                end
                WBURST:  ram_we_c   = DDRAM_WE;
                RBURST:  rd_issue_c = (cnt > BURST_W'(1));
                default: ;
            endcase
        end
    end

    ddram_bram #(
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk  (DDRAM_CLK),
        .addr (ram_addr_c),
        .we   (ram_we_c),
        .be   (DDRAM_BE),
        .din  (DDRAM_DIN),
        .q    (ram_q)
    );

    // Burst FSM, beat counter, address pointer and registered read-data pipeline.
    always_ff @(posedge DDRAM_CLK) begin
        if (reset) begin
            state            <= IDLE;
            ptr              <= '0;
            cnt              <= '0;
            rd_pend          <= 1'b0;
            DDRAM_BUSY       <= 1'b0;
            DDRAM_DOUT_READY <= 1'b0;
            DDRAM_DOUT       <= '0;
        end else begin
            rd_pend          <= rd_issue_c;
            DDRAM_DOUT_READY <= rd_pend;
            if (rd_pend) begin
                DDRAM_DOUT <= ram_q;
            end
            if (rd_issue_c || ram_we_c) begin
                ptr <= ram_addr_c + AW'(1);
            end
            case (state)
                IDLE: begin
                    if (DDRAM_RD) begin
                        cnt        <= burst_n_c;
                        DDRAM_BUSY <= 1'b1;
                        state      <= RBURST;
                    end else if (DDRAM_WE && (burst_n_c > BURST_W'(1))) begin
                        cnt   <= burst_n_c - BURST_W'(1);
                        state <= WBURST;
                    end
                end
                WBURST: begin
                    if (DDRAM_WE) begin
                        cnt <= cnt - BURST_W'(1);
                        if (cnt == BURST_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                RBURST: begin
                    cnt <= cnt - BURST_W'(1);
                    if (cnt == BURST_W'(1)) begin
                        DDRAM_BUSY <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Initiator protocol misuse: simultaneous RD/WE in IDLE, or RD inside a write burst.
    a_no_rd_we_idle: assert property (@(posedge DDRAM_CLK) disable iff (reset)
        !(state == IDLE && DDRAM_RD && DDRAM_WE));
    a_no_rd_in_wburst: assert property (@(posedge DDRAM_CLK) disable iff (reset)
        !(state == WBURST && DDRAM_RD));

endmodule

// File: tb/tb_ddram_bram_responder.sv
// Self-checking bench for ddram_bram_responder: vector table, corner sequences, random traffic.
module tb_ddram_bram_responder;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] addr;
    logic [63:0] dout;
    logic        dout_ready;
    logic        rd;
    logic [63:0] din;
    logic [7:0]  be;
    logic        we;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] model [DEPTH];
    logic [63:0] rd_data [$];

    ddram_bram_responder #(.AW(AW), .INIT_FILE("")) dut (
        .DDRAM_CLK        (clk),
        .reset            (reset),
        .DDRAM_BUSY       (busy),
        .DDRAM_BURSTCNT   (burstcnt),
        .DDRAM_ADDR       (addr),
        .DDRAM_DOUT       (dout),
        .DDRAM_DOUT_READY (dout_ready),
        .DDRAM_RD         (rd),
        .DDRAM_DIN        (din),
        .DDRAM_BE         (be),
        .DDRAM_WE         (we)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        logic [28:0] a;
        logic [7:0]  bc;
        logic [63:0] d;
        logic [7:0]  m;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [28:0] a, input int k);
        return (int'(a[AW-1:0]) + k) % DEPTH;
    endfunction

    // Write burst; stall_mask[k] inserts one WE=0 cycle after beat k.
    task automatic do_write(input logic [28:0] a, input logic [7:0] bc, input logic [63:0] d0,
                            input logic [7:0] m0, input logic [31:0] stall_mask);
        int n;
        int busy_hi;
        logic [63:0] d;
        logic [7:0]  m;
        n = (bc == 0) ? 1 : int'(bc);
        busy_hi = 0;
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : {$urandom, $urandom};
            m = (k == 0) ? m0 : 8'($urandom);
            we = 1'b1; din = d; be = m;
            addr     = (k == 0) ? a  : 29'($urandom);
            burstcnt = (k == 0) ? bc : 8'($urandom);
            if (busy) busy_hi++;
            model[widx(a, k)] = merge(model[widx(a, k)], d, m);
            step();
            if (stall_mask[k] && k < n - 1) begin
                we = 1'b0; din = {$urandom, $urandom};
                if (busy) busy_hi++;
                step();
            end
        end
        we = 1'b0;
        check("wr_busy_cycles", 64'(busy_hi), 64'd0);
    endtask

    // Read burst: checks BUSY/DOUT_READY windows and each beat against the model.
    task automatic do_read(input logic [28:0] a, input logic [7:0] bc);
        int n;
        logic [31:0] bpat, rpat, ebusy;
        n = (bc == 0) ? 1 : int'(bc);
        bpat = '0; rpat = '0;
        rd_data.delete();
        check("rd_busy_at_accept", 64'(busy), 64'd0);
        rd = 1'b1; addr = a; burstcnt = bc;
        step();
        rd = 1'b0; addr = 29'($urandom); burstcnt = 8'($urandom);
        for (int j = 1; j <= n + 2; j++) begin
            bpat[j-1] = busy;
            rpat[j-1] = dout_ready;
            if (dout_ready) rd_data.push_back(dout);
            step();
        end
        ebusy = (32'd1 << n) - 32'd1;
        check("rd_busy_window", 64'(bpat), 64'(ebusy));
        check("rd_ready_window", 64'(rpat), 64'(ebusy << 1));
        for (int k = 0; k < rd_data.size(); k++)
            check("rd_data", rd_data[k], model[widx(a, k)]);
    endtask

    initial begin
        logic [31:0] bpat, rpat;
        logic [63:0] exp4 [4];

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset = 1'b1; rd = 1'b0; we = 1'b0; addr = '0; burstcnt = '0; din = '0; be = '0;
        repeat (3) step();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(dout_ready), 64'd0);
        check("reset_dout", dout, 64'd0);
        reset = 1'b0;
        step();

        // Single-beat vectors with hand-computed read results.
        vecs[0] = '{1'b1, 29'h010, 8'd1, 64'h1122334455667788, 8'hFF, 64'h0};
        vecs[1] = '{1'b0, 29'h010, 8'd1, 64'h0, 8'h00, 64'h1122334455667788};
        vecs[2] = '{1'b1, 29'h005, 8'd1, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h0};
        vecs[3] = '{1'b1, 29'h005, 8'd1, 64'h0, 8'h0F, 64'h0};
        vecs[4] = '{1'b0, 29'h005, 8'd1, 64'h0, 8'h00, 64'hAAAAAAAA00000000};
        vecs[5] = '{1'b1, 29'h007, 8'd0, 64'h0123456789ABCDEF, 8'h81, 64'h0};
        vecs[6] = '{1'b0, 29'h007, 8'd0, 64'h0, 8'h00, 64'h01000000000000EF};
        vecs[7] = '{1'b0, 29'h1ABC0010, 8'd1, 64'h0, 8'h00, 64'h1122334455667788};
        vecs[8] = '{1'b1, 29'h006, 8'd1, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0};
        vecs[9] = '{1'b0, 29'h006, 8'd1, 64'h0, 8'h00, 64'h0};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].a, vecs[i].bc, vecs[i].d, vecs[i].m, 32'd0);
            end else begin
                do_read(vecs[i].a, vecs[i].bc);
                check("vec_beats", 64'(rd_data.size()), 64'd1);
                if (rd_data.size() > 0) check("vec_data", rd_data[0], vecs[i].exp);
            end
        end

        // 4-beat write with stalls after beats 1 and 3, then 4-beat read back.
        do_write(29'h100, 8'd4, 64'hDEADBEEF00000001, 8'hFF, 32'b0101);
        do_read(29'h100, 8'd4);

        // Wrap at the top of the RAM.
        do_write(29'hFFF, 8'd3, 64'h0F0F0F0F0F0F0F0F, 8'hFF, 32'd0);
        do_read(29'hFFF, 8'd1);
        do_read(29'h000, 8'd1);
        do_read(29'h001, 8'd1);
        do_read(29'hFFF, 8'd3);

        // Reset asserted on the third data cycle of an 8-beat read.
        do_write(29'h100, 8'd8, 64'h5555666677778888, 8'hFF, 32'd0);
        rd = 1'b1; addr = 29'h100; burstcnt = 8'd8;
        step();
        rd = 1'b0;
        step();
        for (int j = 0; j < 3; j++) begin
            check("rst_beat_ready", 64'(dout_ready), 64'd1);
            check("rst_beat_data", dout, model[widx(29'h100, j)]);
            if (j == 2) reset = 1'b1;
            step();
        end
        check("rst_busy_after", 64'(busy), 64'd0);
        check("rst_ready_after", 64'(dout_ready), 64'd0);
        check("rst_dout_after", dout, 64'd0);
        reset = 1'b0;
        step();
        check("rst_quiet", 64'({busy, dout_ready}), 64'd0);
        do_read(29'h100, 8'd1);
        do_read(29'h107, 8'd1);

        // Two 2-beat reads, the second accepted in the first burst's BUSY-low cycle.
        exp4[0] = model[widx(29'hFFF, 0)];
        exp4[1] = model[widx(29'hFFF, 1)];
        exp4[2] = model[widx(29'h010, 0)];
        exp4[3] = model[widx(29'h010, 1)];
        bpat = '0; rpat = '0;
        rd_data.delete();
        rd = 1'b1; addr = 29'hFFF; burstcnt = 8'd2;
        step();
        rd = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            bpat[j-1] = busy;
            rpat[j-1] = dout_ready;
            if (dout_ready) rd_data.push_back(dout);
            if (j == 3) begin rd = 1'b1; addr = 29'h010; burstcnt = 8'd2; end
            step();
            rd = 1'b0;
        end
        check("b2b_busy", 64'(bpat), 64'h1B);
        check("b2b_ready", 64'(rpat), 64'h36);
        check("b2b_beats", 64'(rd_data.size()), 64'd4);
        for (int k = 0; k < rd_data.size() && k < 4; k++) check("b2b_data", rd_data[k], exp4[k]);

        // Random traffic against the array model.
        for (int it = 0; it < 60; it++) begin
            logic [28:0] ra;
            logic [7:0]  rbc;
            ra  = {17'($urandom), ($urandom_range(0, 3) == 0) ? 12'($urandom_range(12'hFF8, 12'hFFF))
                                                               : 12'($urandom_range(0, 40))};
            rbc = 8'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 0)
                do_write(ra, rbc, {$urandom, $urandom}, 8'($urandom), $urandom);
            else
                do_read(ra, rbc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
